// File: rtl/slice_scheduler.sv
// Column scheduler for a rotating display. Each accepted theta walks the refresh
// mask, fetches marked scan indices from the frame source and hands columns downstream.
module slice_scheduler #(
    parameter  int NUM_CHANNELS = 2,
    parameter  int SCAN_RATE    = 32,
    parameter  int NUM_ROWS     = 64,
    parameter  int RGB_RES      = 9,
    parameter  int THETA_RES    = 8,
    parameter  int NUM_MODES    = 4,
    localparam int MW = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1,
    localparam int SW = (SCAN_RATE > 1) ? $clog2(SCAN_RATE) : 1,
    localparam int CW = $clog2(SCAN_RATE * NUM_CHANNELS),
    localparam int DW = NUM_CHANNELS * NUM_ROWS * RGB_RES
) (
    input  logic                       clk_in,
    input  logic                       rst_n_in,
    input  logic [THETA_RES-1:0]       theta_in,
    input  logic                       theta_valid_in,
    input  logic [MW-1:0]              mode_in,
    input  logic [SCAN_RATE-1:0]       col_mask_in,
    output logic                       src_req_out,
    output logic [SW-1:0]              src_idx_out,
    output logic [THETA_RES-1:0]       src_theta_out,
    output logic [MW-1:0]              src_mode_out,
    input  logic [DW-1:0]              src_data_in,
    output logic [DW-1:0]              col_data_out,
    output logic [NUM_CHANNELS*CW-1:0] col_num_out,
    output logic                       col_valid_out,
    input  logic                       col_ready_in,
    output logic                       slice_done_out,
    output logic                       overrun_out
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_FETCH = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    localparam logic [SW-1:0] LAST_IDX = SW'(SCAN_RATE - 1);

    state_t                    state_q, state_d;
    logic [SW-1:0]             idx_q, idx_d;
    logic [THETA_RES-1:0]      theta_q, theta_d;
    logic [MW-1:0]             mode_q, mode_d;
    logic [SCAN_RATE-1:0]      mask_q, mask_d;
    logic                      first_q, first_d;
    logic                      valid_q, valid_d;
    logic [DW-1:0]             data_q, data_d;
    logic [NUM_CHANNELS*CW-1:0] num_q, num_d;
    logic                      done_q, done_d;
    logic                      overrun_q, overrun_d;
    logic                      accept_s;

    // A new slice starts on any theta that differs from the latched one, or on the first after reset
    assign accept_s = theta_valid_in && (first_q || (theta_in != theta_q));

    // State register
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; an accept in any state restarts scanning at index 0
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) state_d = ST_SCAN;
                else          state_d = ST_IDLE;
            end
            ST_SCAN: begin
                if (accept_s)                state_d = ST_SCAN;
                else if (mask_q[idx_q])      state_d = ST_FETCH;
                else if (idx_q == LAST_IDX)  state_d = ST_IDLE;
                else                         state_d = ST_SCAN;
            end
            ST_FETCH: begin
                if (accept_s) state_d = ST_SCAN;
                else          state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (accept_s)                state_d = ST_SCAN;
                else if (!col_ready_in)      state_d = ST_HOLD;
                else if (idx_q == LAST_IDX)  state_d = ST_IDLE;
                else                         state_d = ST_SCAN;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath next values: slice context, scan index, held column and status flags
    always_comb begin
        idx_d     = idx_q;
        theta_d   = theta_q;
        mode_d    = mode_q;
        mask_d    = mask_q;
        first_d   = first_q;
        valid_d   = valid_q;
        data_d    = data_q;
        num_d     = num_q;
        done_d    = 1'b0;
        overrun_d = overrun_q;
        if (accept_s) begin
            theta_d   = theta_in;
            mode_d    = mode_in;
            mask_d    = col_mask_in;
            first_d   = 1'b0;
            idx_d     = '0;
            valid_d   = 1'b0;
            overrun_d = overrun_q | (state_q != ST_IDLE);
        end else begin
            case (state_q)
                ST_SCAN: begin
                    if (mask_q[idx_q])           idx_d  = idx_q;
                    else if (idx_q == LAST_IDX)  done_d = 1'b1;
                    else                         idx_d  = idx_q + SW'(1);
                end
                ST_FETCH: begin
                    data_d  = src_data_in;
                    valid_d = 1'b1;
                    for (int c = 0; c < NUM_CHANNELS; c++) begin
                        num_d[c*CW +: CW] = CW'(c * SCAN_RATE) + CW'(idx_q);
                    end
                end
                ST_HOLD: begin
                    if (col_ready_in) begin
                        valid_d = 1'b0;
                        if (idx_q == LAST_IDX) done_d = 1'b1;
                        else                   idx_d  = idx_q + SW'(1);
                    end else begin
                        valid_d = 1'b1;
                    end
                end
                default: valid_d = valid_q;
            endcase
        end
    end

    // Datapath registers
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            idx_q     <= '0;
            theta_q   <= '0;
            mode_q    <= '0;
            mask_q    <= '0;
            first_q   <= 1'b1;
            valid_q   <= 1'b0;
            data_q    <= '0;
            num_q     <= '0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            idx_q     <= idx_d;
            theta_q   <= theta_d;
            mode_q    <= mode_d;
            mask_q    <= mask_d;
            first_q   <= first_d;
            valid_q   <= valid_d;
            data_q    <= data_d;
            num_q     <= num_d;
            done_q    <= done_d;
            overrun_q <= overrun_d;
        end
    end

    // Output logic: request is raised while scanning a marked index
    always_comb begin
        src_req_out = 1'b0;
        case (state_q)
            ST_SCAN: src_req_out = mask_q[idx_q];
            default: src_req_out = 1'b0;
        endcase
    end

    assign src_idx_out    = idx_q;
    assign src_theta_out  = theta_q;
    assign src_mode_out   = mode_q;
    assign col_data_out   = data_q;
    assign col_num_out    = num_q;
    assign col_valid_out  = valid_q;
    assign slice_done_out = done_q;
    assign overrun_out    = overrun_q;

endmodule

// File: tb/tb_slice_scheduler.sv
// Bench for slice_scheduler: directed and random slices checked against an
// event-timeline model derived from the scan rules (one cycle per index, three per fetch).
module tb_slice_scheduler;

    localparam int NCH = 2;
    localparam int SR  = 32;
    localparam int NR  = 64;
    localparam int RR  = 9;
    localparam int TR  = 8;
    localparam int NM  = 4;
    localparam int MW  = 2;
    localparam int SW  = 5;
    localparam int CW  = 6;
    localparam int DW  = NCH * NR * RR;

    logic              clk_in = 1'b0;
    logic              rst_n_in;
    logic [TR-1:0]     theta_in;
    logic              theta_valid_in;
    logic [MW-1:0]     mode_in;
    logic [SR-1:0]     col_mask_in;
    logic              src_req_out;
    logic [SW-1:0]     src_idx_out;
    logic [TR-1:0]     src_theta_out;
    logic [MW-1:0]     src_mode_out;
    logic [DW-1:0]     src_data_in;
    logic [DW-1:0]     col_data_out;
    logic [NCH*CW-1:0] col_num_out;
    logic              col_valid_out;
    logic              col_ready_in;
    logic              slice_done_out;
    logic              overrun_out;

    int passed = 0;
    int total  = 0;
    bit exp_overrun = 1'b0;
    int first_req_c;
    int last_done_c;

    slice_scheduler #(
        .NUM_CHANNELS(NCH), .SCAN_RATE(SR), .NUM_ROWS(NR),
        .RGB_RES(RR), .THETA_RES(TR), .NUM_MODES(NM)
    ) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in),
        .theta_in(theta_in), .theta_valid_in(theta_valid_in),
        .mode_in(mode_in), .col_mask_in(col_mask_in),
        .src_req_out(src_req_out), .src_idx_out(src_idx_out),
        .src_theta_out(src_theta_out), .src_mode_out(src_mode_out),
        .src_data_in(src_data_in), .col_data_out(col_data_out),
        .col_num_out(col_num_out), .col_valid_out(col_valid_out),
        .col_ready_in(col_ready_in), .slice_done_out(slice_done_out),
        .overrun_out(overrun_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs[127:0], exp[127:0]);
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] r = '0;
        for (int i = 0; i < DW; i += 32) r = (r << 32) | DW'($urandom);
        return r;
    endfunction

    function automatic int next_set(input logic [SR-1:0] m, input int pos);
        for (int i = pos; i < SR; i++) if (m[i]) return i;
        return SR;
    endfunction

    function automatic logic [NCH*CW-1:0] make_num(input int idx);
        logic [NCH*CW-1:0] n = '0;
        for (int ch = 0; ch < NCH; ch++) n[ch*CW +: CW] = CW'(ch * SR + idx);
        return n;
    endfunction

    // Run one slice from its accept cycle (cycle 0) to one cycle past completion.
    // stall: 0 = ready high, n>0 = ready low for n hold cycles per column, <0 = random ready.
    task automatic run_slice(input logic [SR-1:0] mask, input logic [TR-1:0] th,
                             input logic [MW-1:0] md, input int stall, input bit dup);
        int pos, base, j, req_c, done_c, nreq, nhs, stall_left;
        bit in_hold, finished;
        logic [DW-1:0] exp_data;
        logic [NCH*CW-1:0] exp_num;
        theta_valid_in = 1'b1;
        theta_in       = th;
        mode_in        = md;
        col_mask_in    = mask;
        col_ready_in   = 1'b1;
        tick();
        theta_valid_in = 1'b0;
        mode_in        = md ^ MW'(1);
        col_mask_in    = ~mask;
        first_req_c = -1;
        last_done_c = -1;
        pos = 0; base = 1; nreq = 0; nhs = 0; finished = 1'b0; in_hold = 1'b0;
        exp_data = '0; exp_num = '0; stall_left = stall;
        j = next_set(mask, pos);
        req_c  = (j < SR) ? base + j - pos : -1;
        done_c = (j < SR) ? -1 : base + SR - pos;
        for (int c = 1; c < 2000 && !finished; c++) begin
            chk("req", src_req_out, (c == req_c));
            chk("valid", col_valid_out, in_hold);
            chk("done", slice_done_out, (c == done_c));
            chk("overrun", overrun_out, exp_overrun);
            if (src_req_out) begin
                nreq++;
                if (first_req_c < 0) first_req_c = c;
            end
            if (slice_done_out) last_done_c = c;
            if (c == req_c) begin
                chk("src_idx", src_idx_out, j);
                chk("src_theta", src_theta_out, th);
                chk("src_mode", src_mode_out, md);
            end
            if (in_hold) begin
                chk("col_num", col_num_out, exp_num);
                chk("col_data", col_data_out, exp_data);
            end
            src_data_in = rand_data();
            if (c == req_c + 1) begin
                exp_data = src_data_in;
                exp_num  = make_num(j);
            end
            if (dup && c == 3) begin
                theta_valid_in = 1'b1;
                theta_in       = th;
                col_mask_in    = $urandom;
            end else begin
                theta_valid_in = 1'b0;
            end
            if (stall < 0) col_ready_in = ($urandom_range(0, 2) == 0);
            else if (in_hold && stall_left > 0) begin
                col_ready_in = 1'b0;
                stall_left--;
            end else col_ready_in = 1'b1;
            // Advance the expected timeline to the next cycle
            if (c == req_c + 1) begin
                in_hold = 1'b1;
                stall_left = stall;
            end else if (in_hold && col_ready_in) begin
                nhs++;
                in_hold = 1'b0;
                pos  = j + 1;
                base = c + 1;
                j = next_set(mask, pos);
                req_c  = (j < SR) ? base + j - pos : -1;
                done_c = (j < SR) ? -1 : base + SR - pos;
            end
            if (c == done_c) finished = 1'b1;
            tick();
        end
        chk("slice_finished", finished, 1'b1);
        chk("req_count", nreq, $countones(mask));
        chk("handshakes", nhs, $countones(mask));
        chk("done_single", slice_done_out, 1'b0);
    endtask

    initial begin
        logic [TR-1:0] th, last_th;
        rst_n_in = 1'b0; theta_in = '0; theta_valid_in = 1'b0; mode_in = '0;
        col_mask_in = '0; src_data_in = '0; col_ready_in = 1'b0;
        #3;
        chk("rst_req", src_req_out, 1'b0);
        chk("rst_valid", col_valid_out, 1'b0);
        chk("rst_done", slice_done_out, 1'b0);
        chk("rst_overrun", overrun_out, 1'b0);
        chk("rst_num", col_num_out, '0);
        @(posedge clk_in); @(posedge clk_in); #1;
        rst_n_in = 1'b1;
        tick();

        run_slice(32'h0000_0009, 8'd5, 2'd1, 0, 1'b0);
        chk("r036_first_req", first_req_c, 1);
        chk("r036_done_cycle", last_done_c, 37);

        run_slice(32'h0000_0001, 8'd6, 2'd2, 10, 1'b0);

        run_slice(32'h0000_0000, 8'd7, 2'd3, 0, 1'b0);
        chk("r041_first_req", first_req_c, -1);
        chk("r041_done_cycle", last_done_c, SR + 1);

        run_slice(32'h0000_0081, 8'd8, 2'd0, 4, 1'b1);
        chk("dup_no_overrun", overrun_out, 1'b0);

        last_th = 8'd8;
        for (int k = 0; k < 4; k++) begin
            do th = TR'($urandom_range(16, 250)); while (th == last_th);
            last_th = th;
            run_slice($urandom & $urandom & $urandom, th, MW'($urandom), -1, 1'b0);
        end

        // Abort during HOLD without ready: theta 5 then theta 6
        theta_valid_in = 1'b1; theta_in = 8'd5; mode_in = 2'd0;
        col_mask_in = 32'h0000_0001; col_ready_in = 1'b0;
        tick();
        theta_valid_in = 1'b0;
        chk("abort_req", src_req_out, 1'b1);
        tick();
        tick();
        chk("abort_hold_valid", col_valid_out, 1'b1);
        theta_valid_in = 1'b1; theta_in = 8'd6; col_mask_in = 32'h0000_0004;
        tick();
        theta_valid_in = 1'b0; col_ready_in = 1'b1;
        exp_overrun = 1'b1;
        for (int c = 4; c <= 38; c++) begin
            chk("abort_req_t", src_req_out, (c == 6));
            chk("abort_valid_t", col_valid_out, (c == 8));
            chk("abort_done_t", slice_done_out, (c == 38));
            chk("abort_overrun_t", overrun_out, 1'b1);
            if (c == 6) begin
                chk("abort_idx", src_idx_out, 2);
                chk("abort_theta", src_theta_out, 6);
            end
            if (c == 8) chk("abort_num", col_num_out, make_num(2));
            tick();
        end

        // Reset asserted mid-FETCH
        theta_valid_in = 1'b1; theta_in = 8'd9; col_mask_in = 32'h0000_0001;
        tick();
        theta_valid_in = 1'b0;
        tick();
        rst_n_in = 1'b0;
        #1;
        chk("rst2_req", src_req_out, 1'b0);
        chk("rst2_valid", col_valid_out, 1'b0);
        chk("rst2_overrun", overrun_out, 1'b0);
        chk("rst2_data", col_data_out, '0);
        chk("rst2_num", col_num_out, '0);
        chk("rst2_theta", src_theta_out, '0);
        chk("rst2_idx", src_idx_out, '0);
        exp_overrun = 1'b0;
        @(posedge clk_in); #1;
        rst_n_in = 1'b1;
        tick();
        run_slice(32'h8000_0010, 8'd0, 2'd2, 1, 1'b0);
        chk("r040_first_req", first_req_c, 5);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
